fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Program-counter and fetch-control stage that sits directly upstream of the synchronous instruction memory.
- Drives the memory read address every cycle and tracks the one-cycle memory latency, so decode knows which PC the current memory output belongs to and whether it is valid.
- Handles start, stall, taken branches (relative or absolute) with a one-slot squash, and halt.
- Maintains a saturating run-cycle counter for emulator statistics.

Parameters:
- addr_width, 9, width of PC and instruction address.
- START_ADDR, 0, PC loaded on reset and on every start.
- CNT_WIDTH, 16, width of the run-cycle counter.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- start_i  input  1  one-cycle pulse; begins execution at START_ADDR.
- stall_i  input  1  hold fetch; PC and fetch outputs frozen.
- branch_taken_i  input  1  decode reports a taken branch for the instruction at fetch_pc_o.
- branch_rel_i  input  1  1 = PC-relative branch, 0 = absolute.
- branch_offset_i  input  addr_width  signed two's-complement offset.
- branch_target_i  input  addr_width  absolute target address.
- halt_i  input  1  decode reports a halt instruction at fetch_pc_o.
- pc_o  output  addr_width  read address to the instruction memory.
- fetch_pc_o  output  addr_width  PC whose instruction is currently on the memory output.
- fetch_valid_o  output  1  memory output is a valid, non-squashed instruction.
- done_o  output  1  program has halted.
- cycle_count_o  output  CNT_WIDTH  cycles spent in RUN.

Behaviour:
- States: IDLE, RUN, HALTED.
- Reset (async, any time, including mid-run): state=IDLE, pc_o=START_ADDR, fetch_pc_o=0, fetch_valid_o=0, done_o=0, cycle_count_o=0.
- IDLE:
  - pc_o holds START_ADDR and fetch_valid_o=0.
  - start_i=1 -> RUN at the next edge; cycle_count_o cleared.
- RUN, per edge, in priority order:
  1. halt_i && fetch_valid_o -> HALTED; fetch_valid_o<=0; done_o<=1; pc_o and fetch_pc_o hold.
  2. stall_i -> pc_o, fetch_pc_o and fetch_valid_o all hold. branch_taken_i is ignored; decode must keep it asserted until the stall is released.
  3. branch_taken_i && fetch_valid_o -> pc_o<=target; fetch_pc_o<=pc_o; fetch_valid_o<=0, squashing the wrong-path slot.
     - Relative branch: target = fetch_pc_o + branch_offset_i.
     - Absolute branch: target = branch_target_i.
  4. Otherwise -> pc_o<=pc_o+1; fetch_pc_o<=pc_o; fetch_valid_o<=1.
- Signals gated by validity: branch_taken_i and halt_i are ignored whenever fetch_valid_o=0.
- Arithmetic:
  - All PC arithmetic is modulo 2^addr_width; (2^addr_width)-1 + 1 wraps to 0. Relative branches wrap the same way.
  - The offset is sign-extended at addr_width, i.e. used as-is.
- cycle_count_o:
  - Increments on every edge spent in RUN, including stalled cycles.
  - Saturates at all-ones.
  - Frozen in IDLE and HALTED.
- Latency:
  - The first RUN cycle presents START_ADDR on pc_o.
  - fetch_valid_o first rises one cycle later, with fetch_pc_o=START_ADDR.
  - Steady state: one valid instruction per cycle.
  - A taken branch costs exactly one bubble.
- HALTED:
  - done_o=1 and fetch_valid_o=0; pc_o holds.
  - start_i -> RUN with pc_o=START_ADDR, done_o<=0, cycle_count_o cleared.
- start_i in RUN is ignored.

Decomposition:
- definitions.sv package holds:
  - fetch_state_t enum {IDLE, RUN, HALTED}.
  - Default address-width constant, shared with instr_mem.
  - START_ADDR default.
- One combinational sub-module, pc_next_calc, computes the next PC.
  - Inputs: pc, fetch_pc, branch_taken, branch_rel, offset, target.
  - Output: next PC.
- The top level holds the FSM, pipeline registers and counter.

Test Plan:
- Reset then start_i pulse -> pc_o sequence 0,1,2,3; fetch_valid_o=0 on the first RUN cycle, then 1 with fetch_pc_o 0,1,2; cycle_count_o increments each cycle.
- Relative branch: at fetch_pc_o=5 (valid), branch_taken_i=1, branch_rel_i=1, offset=-3 (9'h1FD) -> next pc_o=2; one cycle with fetch_valid_o=0; then fetch_pc_o=2 valid.
- Absolute branch: target 9'h1FF, then run on -> pc_o 9'h1FF then 0 (wrap); fetch_pc_o 9'h1FF valid, then 0.
- stall_i held 3 cycles with branch_taken_i=1 -> pc_o/fetch_pc_o/fetch_valid_o frozen for all 3 cycles; branch taken on the first unstalled edge; cycle_count_o still +3.
- halt_i at valid fetch_pc_o=7 (asserted together with stall_i and branch_taken_i) -> HALTED; done_o=1; fetch_valid_o=0; pc_o frozen; counter frozen; a later start_i restarts at pc_o=0 with done_o=0.
- Async reset asserted mid-RUN between clock edges -> all outputs return to reset values immediately; start_i is needed to resume.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: FSM state encoding and the
// default address/counter sizing that the instruction memory also uses.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  // Instruction address width shared with instr_mem
  localparam int ADDR_WIDTH_DEFAULT = 9;

  // PC loaded on reset and on every start
  localparam int START_ADDR_DEFAULT = 0;

  // Width of the run-cycle statistics counter
  localparam int CNT_WIDTH_DEFAULT = 16;

endpackage

// File: rtl/fetch_unit_pc_next_calc.sv
// Next-PC selection: sequential increment or taken-branch target.
// All arithmetic wraps modulo 2^addr_width; the relative offset is
// already sign-extended at addr_width, so a plain add does the job.
module pc_next_calc
  import fetch_unit_pkg::*;
#(
  parameter int addr_width = ADDR_WIDTH_DEFAULT
) (
  input  logic [addr_width-1:0] pc,
  input  logic [addr_width-1:0] fetch_pc,
  input  logic                  branch_taken,
  input  logic                  branch_rel,
  input  logic [addr_width-1:0] offset,
  input  logic [addr_width-1:0] target,
  output logic [addr_width-1:0] next_pc
);

  // Relative branches are measured from the PC of the branching
  // instruction (fetch_pc), not from the address currently on the bus.
  always_comb begin
    next_pc = pc + 1'b1;
    if (branch_taken) begin
      if (branch_rel) begin
        next_pc = fetch_pc + offset;
      end else begin
        next_pc = target;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Program-counter and fetch-control stage in front of a synchronous
// instruction memory. pc_o is the read address issued this cycle;
// fetch_pc_o/fetch_valid_o describe the word the memory is returning
// now (issued one cycle earlier). A taken branch squashes the single
// wrong-path slot already in flight.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int addr_width = ADDR_WIDTH_DEFAULT,
  parameter int START_ADDR = START_ADDR_DEFAULT,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic                  stall_i,
  input  logic                  branch_taken_i,
  input  logic                  branch_rel_i,
  input  logic [addr_width-1:0] branch_offset_i,
  input  logic [addr_width-1:0] branch_target_i,
  input  logic                  halt_i,
  output logic [addr_width-1:0] pc_o,
  output logic [addr_width-1:0] fetch_pc_o,
  output logic                  fetch_valid_o,
  output logic                  done_o,
  output logic [CNT_WIDTH-1:0]  cycle_count_o
);

  localparam logic [addr_width-1:0] START_PC = START_ADDR[addr_width-1:0];

  fetch_state_t state, state_n;

  logic [addr_width-1:0] pc_n;
  logic [addr_width-1:0] fetch_pc_n;
  logic                  fetch_valid_n;
  logic                  done_n;
  logic [CNT_WIDTH-1:0]  cycle_count_n;
  logic [addr_width-1:0] calc_pc;
  logic                  branch_live;

  // Branch and halt requests only mean something when decode is looking
  // at a real instruction; during a bubble they are stale and ignored.
  assign branch_live = branch_taken_i & fetch_valid_o;

  pc_next_calc #(
    .addr_width(addr_width)
  ) u_pc_next_calc (
    .pc          (pc_o),
    .fetch_pc    (fetch_pc_o),
    .branch_taken(branch_live),
    .branch_rel  (branch_rel_i),
    .offset      (branch_offset_i),
    .target      (branch_target_i),
    .next_pc     (calc_pc)
  );

  // State register and fetch pipeline registers; reset clears everything
  // immediately so a mid-run reset needs a fresh start to resume.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      pc_o          <= START_PC;
      fetch_pc_o    <= '0;
      fetch_valid_o <= 1'b0;
      done_o        <= 1'b0;
      cycle_count_o <= '0;
    end else begin
      state         <= state_n;
      pc_o          <= pc_n;
      fetch_pc_o    <= fetch_pc_n;
      fetch_valid_o <= fetch_valid_n;
      done_o        <= done_n;
      cycle_count_o <= cycle_count_n;
    end
  end

  // Next-state and next-register values; in RUN the checks run in order
  // halt, stall, then branch/sequential advance, so a halt wins over a
  // simultaneous stall and a stall holds a pending branch until release.
  always_comb begin
    state_n       = state;
    pc_n          = pc_o;
    fetch_pc_n    = fetch_pc_o;
    fetch_valid_n = fetch_valid_o;
    done_n        = done_o;
    cycle_count_n = cycle_count_o;

    unique case (state)
      IDLE: begin
        pc_n          = START_PC;
        fetch_valid_n = 1'b0;
        if (start_i) begin
          state_n       = RUN;
          cycle_count_n = '0;
        end
      end

      RUN: begin
        if (cycle_count_o != {CNT_WIDTH{1'b1}}) begin
          cycle_count_n = cycle_count_o + 1'b1;
        end
        if (halt_i && fetch_valid_o) begin
          state_n       = HALTED;
          fetch_valid_n = 1'b0;
          done_n        = 1'b1;
        end else if (stall_i) begin
          pc_n          = pc_o;
          fetch_pc_n    = fetch_pc_o;
          fetch_valid_n = fetch_valid_o;
        end else begin
          pc_n          = calc_pc;
          fetch_pc_n    = pc_o;
          fetch_valid_n = ~branch_live;
        end
      end

      HALTED: begin
        fetch_valid_n = 1'b0;
        done_n        = 1'b1;
        if (start_i) begin
          state_n       = RUN;
          pc_n          = START_PC;
          done_n        = 1'b0;
          cycle_count_n = '0;
        end
      end

      default: begin
        state_n       = IDLE;
        pc_n          = START_PC;
        fetch_valid_n = 1'b0;
        done_n        = 1'b0;
      end
    endcase
  end

endmodule
